cover_state_mem: RTL and testbench

Parametrised per-cell cover-state memory for the minesweeper board. It holds the covered, opened, flagged and question-mark state of every cell and serves one read-modify-write request per cycle over a valid/ready handshake. It also keeps live flag and open counters, detects a win, and runs hardware sweeps for board clear and end-of-game reveal. It sits between the input/cursor controller and the renderer and game FSM.

---
 rtl/cover_state_mem_if.sv | 28 ++
 rtl/cover_state_mem.sv | 179 +++++++++++++++++
 tb/tb_cover_state_mem.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cover_state_mem_if.sv
// Request/response channel of the cover-state memory.
// One read-modify-write request per cycle, 1-cycle response.
interface cover_state_mem_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [X_BITS-1:0] req_x;
  logic [Y_BITS-1:0] req_y;
  logic              rsp_valid;
  logic [1:0]        rsp_state;
  logic              rsp_new_open;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_x, req_y,
    input  req_ready, rsp_valid, rsp_state,
    input  rsp_new_open, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y,
    output req_ready, rsp_valid, rsp_state,
    output rsp_new_open, rsp_err
  );
endinterface

// File: rtl/cover_state_mem.sv
// Per-cell cover state (covered/opened/flagged/question) with
// live counters, win detect and init/reveal hardware sweeps.
module cover_state_mem #(
  parameter int X_SIZE   = 16,
  parameter int Y_SIZE   = 16,
  parameter int X_BITS   = 4,
  parameter int Y_BITS   = 4,
  parameter int QMARK_EN = 1,
  parameter int CNT_BITS = X_BITS + Y_BITS + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [CNT_BITS-1:0] mine_count,
  cover_state_mem_if.slave    bus,
  output logic [CNT_BITS-1:0] flag_count,
  output logic [CNT_BITS-1:0] open_count,
  output logic                win,
  output logic                reveal_done
);
  typedef enum logic [1:0] {
    INIT, IDLE, REVEAL
  } state_t;

  localparam int AW = X_BITS + Y_BITS;
  localparam logic [1:0] COV  = 2'b00;
  localparam logic [1:0] OPN  = 2'b01;
  localparam logic [1:0] FLG  = 2'b10;
  localparam logic [1:0] QST  = 2'b11;
  localparam logic [1:0] OP_F = 2'b01;
  localparam logic [1:0] OP_O = 2'b10;
  localparam logic [1:0] OP_R = 2'b11;
  localparam logic [X_BITS-1:0] XLAST =
    X_BITS'(X_SIZE - 1);
  localparam logic [Y_BITS-1:0] YLAST =
    Y_BITS'(Y_SIZE - 1);
  localparam logic [X_BITS:0] XS =
    (X_BITS + 1)'(X_SIZE);
  localparam logic [Y_BITS:0] YS =
    (Y_BITS + 1)'(Y_SIZE);
  localparam logic [CNT_BITS-1:0] TOTAL =
    CNT_BITS'(X_SIZE * Y_SIZE);
  localparam logic [CNT_BITS-1:0] CMAX = '1;

  // Addressed as {y,x}; entries beyond the board are never used
  logic [1:0] mem [2**AW];

  state_t            state, state_n;
  logic [X_BITS-1:0] px, px_n;
  logic [Y_BITS-1:0] py, py_n;
  logic              accept, in_range, last, req_mod;
  logic [1:0]        cur, nxt, sw_cur, sw_nxt;
  logic              new_open, flag_in, flag_out;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [1:0]        wdata;
  logic [CNT_BITS-1:0] flag_n, open_n;

  assign bus.req_ready = (state == IDLE);
  assign accept   = bus.req_valid && bus.req_ready;
  assign in_range = ({1'b0, bus.req_x} < XS) &&
                    ({1'b0, bus.req_y} < YS);
  assign req_mod  = accept && in_range && !clear &&
                    (bus.req_op != OP_R);
  assign cur      = mem[{bus.req_y, bus.req_x}];
  assign sw_cur   = mem[{py, px}];
  assign last     = (px == XLAST) && (py == YLAST);
  assign sw_nxt   = (sw_cur == FLG || sw_cur == OPN) ?
                    sw_cur : OPN;
  assign flag_in  = (nxt == FLG) && (cur != FLG);
  assign flag_out = (cur == FLG) && (nxt != FLG);

  always_comb begin
    nxt      = cur;
    new_open = 1'b0;
    unique case (1'b1)
      bus.req_op == OP_F: begin
        unique case (1'b1)
          cur == COV: nxt = FLG;
          cur == FLG: nxt = (QMARK_EN != 0) ? QST : COV;
          cur == QST: nxt = COV;
          default:    nxt = cur;
        endcase
      end
      bus.req_op == OP_O: begin
        if (cur == COV || cur == QST) begin
          nxt      = OPN;
          new_open = 1'b1;
        end
      end
      default: nxt = cur;
    endcase
  end

  always_comb begin
    state_n = state;
    px_n    = px;
    py_n    = py;
    we      = 1'b0;
    waddr   = {py, px};
    wdata   = COV;
    flag_n  = flag_count;
    open_n  = open_count;
    if (clear) begin
      state_n = INIT;
      px_n    = '0;
      py_n    = '0;
      flag_n  = '0;
      open_n  = '0;
    end else begin
      unique case (state)
        INIT, REVEAL: begin
          we    = 1'b1;
          wdata = (state == REVEAL) ? sw_nxt : COV;
          if (px == XLAST) begin
            px_n = '0;
            py_n = last ? '0 : py + 1'b1;
          end else begin
            px_n = px + 1'b1;
          end
          if (last) state_n = IDLE;
        end
        IDLE: begin
          if (accept && bus.req_op == OP_R) begin
            state_n = REVEAL;
            px_n    = '0;
            py_n    = '0;
          end else if (req_mod) begin
            we    = 1'b1;
            waddr = {bus.req_y, bus.req_x};
            wdata = nxt;
            if (flag_in && flag_count != CMAX)
              flag_n = flag_count + 1'b1;
            if (flag_out && flag_count != '0)
              flag_n = flag_count - 1'b1;
            if (new_open && open_count != CMAX)
              open_n = open_count + 1'b1;
          end
        end
        default: state_n = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= INIT;
      px               <= '0;
      py               <= '0;
      flag_count       <= '0;
      open_count       <= '0;
      win              <= 1'b0;
      reveal_done      <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_state    <= COV;
      bus.rsp_new_open <= 1'b0;
      bus.rsp_err      <= 1'b0;
    end else begin
      state            <= state_n;
      px               <= px_n;
      py               <= py_n;
      flag_count       <= flag_n;
      open_count       <= open_n;
      win              <= (state_n == IDLE) &&
                          (open_n == TOTAL - mine_count);
      reveal_done      <= !clear && (state == REVEAL) &&
                          last;
      bus.rsp_valid    <= accept && !clear;
      bus.rsp_state    <= req_mod ? nxt : COV;
      bus.rsp_new_open <= req_mod && new_open;
      bus.rsp_err      <= accept && !clear && !in_range &&
                          (bus.req_op != OP_R);
    end
  end
endmodule

// File: tb/tb_cover_state_mem.sv
// Scoreboard bench for cover_state_mem on a 4x3 board.
// Second instance exercises the no-question-mark flag cycle.
module tb_cover_state_mem;
  localparam int XS = 4;
  localparam int YS = 3;
  localparam int XB = 3;
  localparam int YB = 2;
  localparam int CB = XB + YB + 1;
  localparam int N  = XS * YS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic [CB-1:0] mine_count = CB'(2);
  logic [CB-1:0] flag_count, open_count;
  logic [CB-1:0] flag0, open0;
  logic win, reveal_done, win0, rd0;

  cover_state_mem_if #(.X_BITS(XB), .Y_BITS(YB)) bus ();
  cover_state_mem_if #(.X_BITS(XB), .Y_BITS(YB)) bus0 ();

  cover_state_mem #(
    .X_SIZE(XS), .Y_SIZE(YS), .X_BITS(XB),
    .Y_BITS(YB), .QMARK_EN(1), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .mine_count(mine_count), .bus(bus.slave),
    .flag_count(flag_count), .open_count(open_count),
    .win(win), .reveal_done(reveal_done)
  );

  cover_state_mem #(
    .X_SIZE(XS), .Y_SIZE(YS), .X_BITS(XB),
    .Y_BITS(YB), .QMARK_EN(0), .CNT_BITS(CB)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(1'b0),
    .mine_count(mine_count), .bus(bus0.slave),
    .flag_count(flag0), .open_count(open0),
    .win(win0), .reveal_done(rd0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    st;
    logic          nw;
    logic          er;
    logic [CB-1:0] fc;
    logic [CB-1:0] oc;
    logic          w;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [1:0] mdl [XS][YS];
  int mflag = 0;
  int mopen = 0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp got rsp_valid=1 want none");
      end else begin
        e = sb.pop_front();
        if (bus.rsp_state !== e.st) begin
          bad++;
          $display("FAIL rsp_state got=%b want=%b",
                   bus.rsp_state, e.st);
        end
        total++;
        if (bus.rsp_new_open !== e.nw) begin
          bad++;
          $display("FAIL rsp_new_open got=%b want=%b",
                   bus.rsp_new_open, e.nw);
        end
        total++;
        if (bus.rsp_err !== e.er) begin
          bad++;
          $display("FAIL rsp_err got=%b want=%b",
                   bus.rsp_err, e.er);
        end
        total++;
        if (flag_count !== e.fc) begin
          bad++;
          $display("FAIL flag_count got=%0d want=%0d",
                   flag_count, e.fc);
        end
        total++;
        if (open_count !== e.oc) begin
          bad++;
          $display("FAIL open_count got=%0d want=%0d",
                   open_count, e.oc);
        end
        total++;
        if (win !== e.w) begin
          bad++;
          $display("FAIL win got=%b want=%b", win, e.w);
        end
      end
    end
  end

  task automatic model_clear();
    for (int x = 0; x < XS; x++)
      for (int y = 0; y < YS; y++)
        mdl[x][y] = 2'b00;
    mflag = 0;
    mopen = 0;
  endtask

  task automatic issue(input logic [1:0] op,
                       input int x, input int y);
    exp_t e;
    int n;
    logic [1:0] c, nx;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 100) begin
      bus.req_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got ready=%b want 1",
               bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_x = XB'(x);
    bus.req_y = YB'(y);
    e.nw = 1'b0;
    e.er = 1'b0;
    e.st = 2'b00;
    if (op == 2'b11) begin
      for (int i = 0; i < XS; i++)
        for (int j = 0; j < YS; j++)
          if (mdl[i][j] == 2'b00 || mdl[i][j] == 2'b11)
            mdl[i][j] = 2'b01;
    end else if (x >= XS || y >= YS) begin
      e.er = 1'b1;
    end else begin
      c = mdl[x][y];
      nx = c;
      if (op == 2'b01) begin
        case (c)
          2'b00: nx = 2'b10;
          2'b10: nx = 2'b11;
          2'b11: nx = 2'b00;
          default: nx = c;
        endcase
      end
      if (op == 2'b10 && (c == 2'b00 || c == 2'b11)) begin
        nx = 2'b01;
        e.nw = 1'b1;
        mopen++;
      end
      if (c != 2'b10 && nx == 2'b10) mflag++;
      if (c == 2'b10 && nx != 2'b10) mflag--;
      mdl[x][y] = nx;
      e.st = nx;
    end
    e.fc = CB'(mflag);
    e.oc = CB'(mopen);
    e.w = (op != 2'b11) && (mopen == N - int'(mine_count));
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Call at a negedge where req_ready is low
  task automatic count_low(input string name,
                           input int want_rd);
    int n, rd;
    n = 0;
    rd = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      bus.req_valid = 1'b0;
      clear = 1'b0;
      if (reveal_done === 1'b1) rd++;
    end
    @(negedge clk);
    if (reveal_done === 1'b1) rd++;
    total++;
    if (n != N) begin
      bad++;
      $display("FAIL %s ready_low got=%0d want=%0d",
               name, n, N);
    end
    total++;
    if (rd != want_rd) begin
      bad++;
      $display("FAIL %s reveal_done_pulses got=%0d want=%0d",
               name, rd, want_rd);
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [9:0] got;
    got = {bus.req_ready, bus.rsp_valid, bus.rsp_state,
           bus.rsp_new_open, bus.rsp_err, win,
           reveal_done, |flag_count, |open_count};
    total++;
    if (got !== 10'b0) begin
      bad++;
      $display("FAIL %s reset_outputs got=%b want=%b",
               name, got, 10'b0);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.req_valid = 1'b0;
    clear = 1'b1;
    model_clear();
    @(negedge clk);
    clear = 1'b0;
    count_low("clear", 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus0.req_valid = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    count_low("reset", 0);
    total++;
    if (bus0.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL noq_ready got=%b want=1",
               bus0.req_ready);
    end
  endtask

  task automatic test_query_all();
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++)
        issue(2'b00, x, y);
    idle();
  endtask

  task automatic test_flag_cycle();
    repeat (4) issue(2'b01, 2, 1);
    idle();
  endtask

  task automatic test_flag_noq();
    logic [1:0] ws;
    logic [CB-1:0] wf;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_op = 2'b01;
    bus0.req_x = XB'(0);
    bus0.req_y = YB'(0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) bus0.req_valid = 1'b0;
      ws = (i == 0) ? 2'b10 : 2'b00;
      wf = (i == 0) ? CB'(1) : CB'(0);
      total++;
      if (bus0.rsp_valid !== 1'b1 ||
          bus0.rsp_state !== ws) begin
        bad++;
        $display("FAIL noq_state got=%b/%b want=1/%b",
                 bus0.rsp_valid, bus0.rsp_state, ws);
      end
      total++;
      if (flag0 !== wf) begin
        bad++;
        $display("FAIL noq_flag_count got=%0d want=%0d",
                 flag0, wf);
      end
    end
  endtask

  task automatic test_open();
    issue(2'b10, 0, 0);
    issue(2'b10, 0, 0);
    issue(2'b10, 2, 1);
    idle();
  endtask

  task automatic test_win();
    do_clear();
    for (int i = 0; i < 10; i++)
      issue(2'b10, i % XS, i / XS);
    idle();
    total++;
    if (win !== 1'b1) begin
      bad++;
      $display("FAIL win_level got=%b want=1", win);
    end
    issue(2'b00, 4, 0);
    issue(2'b01, 0, 3);
    idle();
  endtask

  task automatic test_reveal();
    do_clear();
    issue(2'b01, 1, 1);
    issue(2'b11, 3, 2);
    idle();
    count_low("reveal", 1);
    for (int y = 0; y < YS; y++)
      for (int x = 0; x < XS; x++)
        issue(2'b00, x, y);
    idle();
  endtask

  task automatic test_clear_accept();
    issue(2'b10, 1, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b10;
    bus.req_x = XB'(0);
    bus.req_y = YB'(0);
    clear = 1'b1;
    model_clear();
    @(negedge clk);
    bus.req_valid = 1'b0;
    clear = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear_rsp_valid got=%b want=0",
               bus.rsp_valid);
    end
    total++;
    if (flag_count !== '0 || open_count !== '0) begin
      bad++;
      $display("FAIL clear_counts got=%0d/%0d want=0/0",
               flag_count, open_count);
    end
    count_low("clear_accept", 0);
    issue(2'b00, 0, 0);
    issue(2'b00, 1, 1);
    idle();
  endtask

  task automatic test_reset_mid();
    issue(2'b01, 3, 2);
    idle();
    @(negedge clk);
    clear = 1'b1;
    model_clear();
    @(negedge clk);
    clear = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_mid");
    @(negedge clk);
    reset_n = 1'b1;
    count_low("reset_mid", 0);
    issue(2'b00, 3, 2);
    idle();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_x = '0;
    bus.req_y = '0;
    bus0.req_valid = 1'b0;
    bus0.req_op = 2'b00;
    bus0.req_x = '0;
    bus0.req_y = '0;
    test_reset();
    test_query_all();
    test_flag_cycle();
    test_flag_noq();
    test_open();
    test_win();
    test_reveal();
    test_clear_accept();
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_rsp got=%0d pending want=0",
               sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
